rs232_rxc: RTL and testbench

- Configurable, buffered RS232 receiver. Next generation of the buffered receiver.
- Contains its own oversampling receive FSM. Supports 5-8 data bits, optional even/odd parity, and two runtime-selectable baud rates.
- Each received character is pushed into a FIFO together with its parity and framing error flags. A sticky overrun flag records characters dropped while the FIFO was full.
- Sits behind the IO address decoder. The CPU reads data plus status from the FIFO head.

---
 rtl/rs232_pkg.sv | 31 +++
 rtl/fifo.sv | 77 +++++++
 rtl/rs232_rx_core.sv | 115 +++++++++++
 rtl/rs232_rxc.sv | 106 ++++++++++
 tb/tb_rs232_rxc.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the buffered RS232 receiver: parity modes, receive
// FSM state encoding, FIFO entry layout and the bit-time divisor helper.
package rs232_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } rx_state_e;

    // One received character as stored in the FIFO.
    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned bit_cycles(input int unsigned clock_freq,
                                               input int unsigned baud);
        return (clock_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO of arbitrary depth.
// Ports: clk, rst_n (sync, active low), wr/wdata push, rd pop,
// rdata head entry (zero when empty), empty/full registered flags.
// Pushes while full and pops while empty are ignored.
module fifo #(
    parameter int unsigned data_width = 8,
    parameter int unsigned depth      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [data_width-1:0] wdata,
    input  logic                  rd,
    output logic [data_width-1:0] rdata,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CNT_W = $clog2(depth + 1);

    logic [data_width-1:0] mem [depth];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    // Head is presented combinationally; zero while nothing is queued.
    assign rdata = empty ? '0 : mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10: begin
                    count <= count + CNT_W'(1);
                    empty <= 1'b0;
                    full  <= (count == CNT_W'(depth - 1));
                end
                2'b01: begin
                    count <= count - CNT_W'(1);
                    full  <= 1'b0;
                    empty <= (count == CNT_W'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rs232_rx_core.sv
// Oversampling RS232 receive FSM.
// Ports: clk, rst_n (sync, active low), rxd_s synchronised line,
// div bit time in clocks (latched when a start edge is seen),
// data received character (zero-extended), perr parity error,
// ferr framing error (valid with push), push one-cycle strobe at the
// stop-bit sample.
module rs232_rx_core
    import rs232_pkg::*;
#(
    parameter int unsigned data_bits = 8,
    parameter int unsigned parity    = PAR_NONE,
    parameter int unsigned cnt_w     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd_s,
    input  logic [cnt_w-1:0] div,
    output logic [7:0]       data,
    output logic             perr,
    output logic             ferr,
    output logic             push
);

    localparam int unsigned IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_bits - 1);
    localparam logic             ODD_PAR  = 1'(parity == PAR_ODD);
    localparam logic             USE_PAR  = 1'(parity != PAR_NONE);

    rx_state_e        state;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] div_q;
    logic [IDX_W-1:0] idx;
    logic             expire;

    assign expire = (cnt == '0);

    // The entry is pushed in the same cycle the stop bit is sampled.
    assign push = (state == STOP) && expire;
    assign ferr = ~rxd_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            div_q <= '0;
            idx   <= '0;
            data  <= '0;
            perr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        div_q <= div;
                        cnt   <= (div >> 1) - cnt_w'(1);
                        idx   <= '0;
                        data  <= '0;
                        perr  <= 1'b0;
                    end
                end
                START: begin
                    if (expire) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state <= DATA;
                            cnt   <= div_q - cnt_w'(1);
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt - cnt_w'(1);
                    end
                end
                DATA: begin
                    if (expire) begin
                        data[idx] <= rxd_s;
                        cnt       <= div_q - cnt_w'(1);
                        if (idx == LAST_IDX) begin
                            state <= USE_PAR ? PAR : STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt - cnt_w'(1);
                    end
                end
                PAR: begin
                    if (expire) begin
                        // Bits above data_bits are zero, so a full reduction is safe.
                        perr  <= (^data) ^ rxd_s ^ ODD_PAR;
                        cnt   <= div_q - cnt_w'(1);
                        state <= STOP;
                    end else begin
                        cnt <= cnt - cnt_w'(1);
                    end
                end
                STOP: begin
                    if (expire) begin
                        state <= rxd_s ? IDLE : BRK;
                    end else begin
                        cnt <= cnt - cnt_w'(1);
                    end
                end
                BRK: begin
                    // Hold off until the line returns high so a break cannot re-trigger.
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/rs232_rxc.sv
// Buffered RS232 receiver: synchroniser, receive FSM and character FIFO.
// Ports: clk, rst_n (sync, active low), fsel baud select (1 fast, 0 slow),
// rxd serial line, rd pop head, clr_ovr clear overrun;
// data_out/perr/ferr head entry (show-ahead), empty, full, ovr sticky overrun.
module rs232_rxc
    import rs232_pkg::*;
#(
    parameter int unsigned clock_freq = 50000000,
    parameter int unsigned baud_fast  = 115200,
    parameter int unsigned baud_slow  = 19200,
    parameter int unsigned data_bits  = 8,
    parameter int unsigned parity     = PAR_NONE,
    parameter int unsigned num_slots  = 63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fsel,
    input  logic       rxd,
    input  logic       rd,
    input  logic       clr_ovr,
    output logic [7:0] data_out,
    output logic       perr,
    output logic       ferr,
    output logic       empty,
    output logic       full,
    output logic       ovr
);

    localparam int unsigned BIT_FAST = bit_cycles(clock_freq, baud_fast);
    localparam int unsigned BIT_SLOW = bit_cycles(clock_freq, baud_slow);
    localparam int unsigned CNT_W    = $clog2(BIT_SLOW);

    logic             rxd_m;
    logic             rxd_s;
    logic [CNT_W-1:0] div;
    logic [7:0]       core_data;
    logic             core_perr;
    logic             core_ferr;
    logic             push;
    logic             push_ok;
    rx_entry_t        wr_entry;
    rx_entry_t        rd_entry;

    // Two-flop synchroniser, preloaded to the idle line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    assign div = fsel ? CNT_W'(BIT_FAST) : CNT_W'(BIT_SLOW);

    rs232_rx_core #(
        .data_bits (data_bits),
        .parity    (parity),
        .cnt_w     (CNT_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd_s (rxd_s),
        .div   (div),
        .data  (core_data),
        .perr  (core_perr),
        .ferr  (core_ferr),
        .push  (push)
    );

    assign wr_entry = '{ferr: core_ferr, perr: core_perr, data: core_data};

    // Fullness is judged before any same-cycle pop, so a pop never rescues a push.
    assign push_ok = push && !full;

    fifo #(
        .data_width ($bits(rx_entry_t)),
        .depth      (num_slots)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (push_ok),
        .wdata (wr_entry),
        .rd    (rd),
        .rdata (rd_entry),
        .empty (empty),
        .full  (full)
    );

    assign data_out = rd_entry.data;
    assign perr     = rd_entry.perr;
    assign ferr     = rd_entry.ferr;

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr <= 1'b0;
        end else if (push && full) begin
            ovr <= 1'b1;
        end else if (clr_ovr) begin
            ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs232_rxc.sv
// Directed bench for rs232_rxc with three instances:
// u_a 8N1 63 slots, u_b 7E1 63 slots, u_c 8N1 4 slots.
module tb_rs232_rxc;

    localparam int BT_FAST = 434;
    localparam int BT_SLOW = 2604;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n_v;
    logic [2:0]       fsel_v;
    logic [2:0]       rxd_v;
    logic [2:0]       rd_v;
    logic [2:0]       clr_v;
    wire  [2:0][7:0]  dout_v;
    wire  [2:0]       perr_v;
    wire  [2:0]       ferr_v;
    wire  [2:0]       empty_v;
    wire  [2:0]       full_v;
    wire  [2:0]       ovr_v;

    int n_tests = 0;
    int n_fail  = 0;

    rs232_rxc u_a (
        .clk(clk), .rst_n(rst_n_v[0]), .fsel(fsel_v[0]), .rxd(rxd_v[0]),
        .rd(rd_v[0]), .clr_ovr(clr_v[0]), .data_out(dout_v[0]),
        .perr(perr_v[0]), .ferr(ferr_v[0]), .empty(empty_v[0]),
        .full(full_v[0]), .ovr(ovr_v[0])
    );

    rs232_rxc #(.data_bits(7), .parity(1)) u_b (
        .clk(clk), .rst_n(rst_n_v[1]), .fsel(fsel_v[1]), .rxd(rxd_v[1]),
        .rd(rd_v[1]), .clr_ovr(clr_v[1]), .data_out(dout_v[1]),
        .perr(perr_v[1]), .ferr(ferr_v[1]), .empty(empty_v[1]),
        .full(full_v[1]), .ovr(ovr_v[1])
    );

    rs232_rxc #(.num_slots(4)) u_c (
        .clk(clk), .rst_n(rst_n_v[2]), .fsel(fsel_v[2]), .rxd(rxd_v[2]),
        .rd(rd_v[2]), .clr_ovr(clr_v[2]), .data_out(dout_v[2]),
        .perr(perr_v[2]), .ferr(ferr_v[2]), .empty(empty_v[2]),
        .full(full_v[2]), .ovr(ovr_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive seq[0..n-1] LSB first, bt clocks per bit. With chk set, probe
    // empty just before and just after the stop-bit midpoint.
    task automatic send(input int u, input logic [11:0] seq, input int n,
                        input int bt, input bit chk, input string tag);
        for (int i = 0; i < n - 1; i++) begin
            rxd_v[u] = seq[i];
            repeat (bt) @(negedge clk);
        end
        rxd_v[u] = seq[n-1];
        if (chk) begin
            repeat (bt / 2 - 2) @(negedge clk);
            check({tag, "_pre_mid_empty"}, 32'(empty_v[u]), 32'd1);
            repeat (6) @(negedge clk);
            check({tag, "_post_mid_empty"}, 32'(empty_v[u]), 32'd0);
            repeat (bt - bt / 2 - 4) @(negedge clk);
        end else begin
            repeat (bt) @(negedge clk);
        end
    endtask

    task automatic pop(input int u);
        rd_v[u] = 1'b1;
        @(negedge clk);
        rd_v[u] = 1'b0;
    endtask

    initial begin
        rst_n_v = '0;
        fsel_v  = '1;
        rxd_v   = '1;
        rd_v    = '0;
        clr_v   = '0;
        repeat (3) @(negedge clk);
        rst_n_v = '1;

        check("rst_empty", 32'(empty_v[0]), 32'd1);
        check("rst_full",  32'(full_v[0]),  32'd0);
        check("rst_dout",  32'(dout_v[0]),  32'h0);
        check("rst_perr",  32'(perr_v[0]),  32'd0);
        check("rst_ferr",  32'(ferr_v[0]),  32'd0);
        check("rst_ovr",   32'(ovr_v[0]),   32'd0);

        fork
            // 8N1: basic frame, break, slow baud, reset mid-frame.
            begin
                send(0, {1'b1, 8'hA5, 1'b0}, 10, BT_FAST, 1'b1, "a5");
                check("a5_dout", 32'(dout_v[0]), 32'hA5);
                check("a5_perr", 32'(perr_v[0]), 32'd0);
                check("a5_ferr", 32'(ferr_v[0]), 32'd0);
                pop(0);
                check("a5_pop_empty", 32'(empty_v[0]), 32'd1);

                send(0, {1'b0, 8'h55, 1'b0}, 10, BT_FAST, 1'b0, "brk");
                repeat (5 * BT_FAST) @(negedge clk);
                check("brk_empty", 32'(empty_v[0]), 32'd0);
                check("brk_dout",  32'(dout_v[0]),  32'h55);
                check("brk_ferr",  32'(ferr_v[0]),  32'd1);
                pop(0);
                check("brk_single_entry", 32'(empty_v[0]), 32'd1);
                rxd_v[0] = 1'b1;
                repeat (20) @(negedge clk);

                fsel_v[0] = 1'b0;
                rxd_v[0] = 1'b0;
                repeat (10) @(negedge clk);
                rxd_v[0] = 1'b1;
                repeat (3000) @(negedge clk);
                check("glitch_empty", 32'(empty_v[0]), 32'd1);
                send(0, {1'b1, 8'h3C, 1'b0}, 10, BT_SLOW, 1'b1, "slow");
                check("slow_dout", 32'(dout_v[0]), 32'h3C);
                check("slow_ferr", 32'(ferr_v[0]), 32'd0);
                pop(0);

                fsel_v[0] = 1'b1;
                send(0, {1'b1, 8'h11, 1'b0}, 10, BT_FAST, 1'b0, "q1");
                send(0, {1'b1, 8'h22, 1'b0}, 10, BT_FAST, 1'b0, "q2");
                check("q_dout", 32'(dout_v[0]), 32'h11);
                rxd_v[0] = 1'b0;
                repeat (2 * BT_FAST) @(negedge clk);
                rxd_v[0] = 1'b1;
                repeat (200) @(negedge clk);
                rst_n_v[0] = 1'b0;
                @(negedge clk);
                check("midrst_empty", 32'(empty_v[0]), 32'd1);
                check("midrst_ovr",   32'(ovr_v[0]),   32'd0);
                rst_n_v[0] = 1'b1;
                repeat (10 * BT_FAST) @(negedge clk);
                check("partial_no_entry", 32'(empty_v[0]), 32'd1);
                send(0, {1'b1, 8'h7E, 1'b0}, 10, BT_FAST, 1'b1, "7e");
                check("7e_dout", 32'(dout_v[0]), 32'h7E);
                check("7e_ferr", 32'(ferr_v[0]), 32'd0);
            end
            // 7E1: parity bit wrong, then right.
            begin
                send(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10, BT_FAST, 1'b1, "par1");
                check("par1_dout", 32'(dout_v[1]), 32'h41);
                check("par1_perr", 32'(perr_v[1]), 32'd1);
                pop(1);
                send(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10, BT_FAST, 1'b1, "par0");
                check("par0_dout", 32'(dout_v[1]), 32'h41);
                check("par0_perr", 32'(perr_v[1]), 32'd0);
                pop(1);
                check("par_empty", 32'(empty_v[1]), 32'd1);
            end
            // 4-slot FIFO: fill, overrun, drain, clear.
            begin
                for (int k = 1; k <= 4; k++) begin
                    send(2, {1'b1, 8'(k), 1'b0}, 10, BT_FAST, 1'b0, "fill");
                end
                check("fill4_full", 32'(full_v[2]), 32'd1);
                check("fill4_ovr",  32'(ovr_v[2]),  32'd0);
                send(2, {1'b1, 8'h05, 1'b0}, 10, BT_FAST, 1'b0, "fill5");
                check("fill5_full", 32'(full_v[2]), 32'd1);
                check("fill5_ovr",  32'(ovr_v[2]),  32'd1);
                for (int k = 1; k <= 4; k++) begin
                    check("drain_dout", 32'(dout_v[2]), 32'(k));
                    pop(2);
                end
                check("drain_empty", 32'(empty_v[2]), 32'd1);
                check("drain_full",  32'(full_v[2]),  32'd0);
                pop(2);
                check("empty_rd_dout", 32'(dout_v[2]), 32'h0);
                check("ovr_sticky", 32'(ovr_v[2]), 32'd1);
                clr_v[2] = 1'b1;
                @(negedge clk);
                clr_v[2] = 1'b0;
                check("ovr_clear", 32'(ovr_v[2]), 32'd0);
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
